// File: rtl/aes_enc_pkg.sv
// Shared types and GF(2^8)/S-box helpers for the AES encryption round.
package aes_enc_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [31:0]  word_t;
  typedef logic [127:0] state_t;

  typedef enum logic [1:0] {IDLE, LOOKUP, DRAIN, DONE} fsm_t;

  function automatic word_t ror8(word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  // Byte 0 is the most significant byte of the state.
  function automatic byte_t get_byte(state_t s, logic [3:0] idx);
    return s[8*(15-int'(idx)) +: 8];
  endfunction

  function automatic word_t get_word(state_t s, logic [1:0] c);
    return s[32*(3-int'(c)) +: 32];
  endfunction

  function automatic byte_t xtime(byte_t x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(byte_t a, byte_t b);
    byte_t p;
    byte_t x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254; maps 0 to 0 as AES requires.
  function automatic byte_t ginv(byte_t x);
    byte_t r;
    byte_t sq;
    r  = 8'h01;
    sq = x;
    for (int i = 1; i < 8; i++) begin
      sq = gmul(sq, sq);
      r  = gmul(r, sq);
    end
    return r;
  endfunction

  function automatic byte_t sbox(byte_t x);
    byte_t b;
    b = ginv(x);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^
           {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_enc_round_tboxe0.sv
// Te0 table with registered output: q = {2S(a), S(a), S(a), 3S(a)} one cycle after a.
import aes_enc_pkg::*;

module tboxe0 (
  input  logic        clk,
  input  logic [7:0]  a,
  output logic [31:0] q
);

  byte_t s;
  assign s = sbox(a);

  always_ff @(posedge clk) begin
    q <= {xtime(s), s, s, xtime(s) ^ s};
  end

endmodule

// File: rtl/aes_enc_round.sv
// One AES encryption round using 16 serial Te0 lookups.
// Optional macro AES_FINAL_ROUND_EN: honour final_round (SubBytes-only contributions).
import aes_enc_pkg::*;

module aes_enc_round (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] rkey,
  input  logic         final_round,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  fsm_t       state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] pcnt;
  logic       pend;
  state_t     st_q, rk_q, out_q;
  word_t      acc, acc_nxt, contrib, te;
  byte_t      rom_a;
  logic [1:0] src_col;

`ifdef AES_FINAL_ROUND_EN
  logic fin_q;
`else
  logic final_unused;
  assign final_unused = final_round;
`endif

  // ShiftRows folded into the addressing: row r of column c reads column c+r.
  assign src_col = cnt[3:2] + cnt[1:0];
  assign rom_a   = get_byte(st_q, {src_col, cnt[1:0]});

  tboxe0 u_tbox (
    .clk (clk),
    .a   (rom_a),
    .q   (te)
  );

  always_comb begin
    contrib = te;
    case (pcnt[1:0])
      2'd0:    contrib = te;
      2'd1:    contrib = ror8(te);
      2'd2:    contrib = ror8(ror8(te));
      default: contrib = ror8(ror8(ror8(te)));
    endcase
`ifdef AES_FINAL_ROUND_EN
    if (fin_q) begin
      case (pcnt[1:0])
        2'd0:    contrib = {te[23:16], 24'h0};
        2'd1:    contrib = {8'h0, te[23:16], 16'h0};
        2'd2:    contrib = {16'h0, te[23:16], 8'h0};
        default: contrib = {24'h0, te[23:16]};
      endcase
    end
`endif
    acc_nxt = ((pcnt[1:0] == 2'd0) ? get_word(rk_q, pcnt[3:2]) : acc) ^ contrib;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = LOOKUP;
      LOOKUP:  if (cnt == 4'd15) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign state_out = out_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
      pcnt  <= '0;
      pend  <= 1'b0;
      st_q  <= '0;
      rk_q  <= '0;
      acc   <= '0;
      out_q <= '0;
`ifdef AES_FINAL_ROUND_EN
      fin_q <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        st_q <= state_in;
        rk_q <= rkey;
        cnt  <= '0;
`ifdef AES_FINAL_ROUND_EN
        fin_q <= final_round;
`endif
      end else if (state == LOOKUP) begin
        cnt <= cnt + 4'd1;
      end
      // Table data lags its address by one cycle; pcnt tags which byte it is.
      pend <= (state == LOOKUP);
      pcnt <= cnt;
      if (pend) begin
        acc <= acc_nxt;
        if (pcnt[1:0] == 2'd3) out_q[32*(3-int'(pcnt[3:2])) +: 32] <= acc_nxt;
      end
    end
  end

endmodule

// File: tb/tb_aes_enc_round.sv
// Directed bench for aes_enc_round: FIPS-197 vectors, latency, backpressure, reset, streaming.
`timescale 1ns/1ps
module tb_aes_enc_round;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] state_in = '0;
  logic [127:0] rkey = '0;
  logic         final_round = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] state_out;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] R1_IN  = 128'h193de3bea0f4e22b9ac68d2ae9f84808;
  localparam logic [127:0] R1_KEY = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] R1_OUT = 128'ha49c7ff2689f352b6b5bea43026a5049;
  localparam logic [127:0] R2_KEY = 128'hf2c295f27a96b9435935807a7359f67f;
  localparam logic [127:0] R2_OUT = 128'haa8f5f0361dde3ef82d24ad26832469a;
  localparam logic [127:0] R3_KEY = 128'h3d80477d4716fe3e1e237e446d7a883b;
  localparam logic [127:0] R3_OUT = 128'h486c4eee671d9d0d4de3b138d65f58e7;
  localparam logic [127:0] Z_OUT  = {16{8'h63}};

  always #5 clk = ~clk;

  aes_enc_round dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .state_in    (state_in),
    .rkey        (rkey),
    .final_round (final_round),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .state_out   (state_out)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one round and returns the result and latency in edges, counting the accepting edge as 1.
  task automatic run_round(input logic [127:0] s, input logic [127:0] k, input logic f,
                           output logic [127:0] res, output int lat);
    int n;
    n = 0;
    state_in = s; rkey = k; final_round = f; in_valid = 1'b1;
    while (!in_ready && n < 50) begin step(); n++; end
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 60) begin step(); lat++; end
    res = state_out;
    if (!out_valid) begin
      checks++; errors++;
      $display("FAIL run_round_timeout: out_valid=%0b after %0d edges, required 1", out_valid, lat);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    step(); step();
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (state_out !== 128'h0) begin errors++; $display("FAIL reset_state_out: got %h want 0", state_out); end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_zero();
    logic [127:0] res;
    int lat;
    run_round(128'h0, 128'h0, 1'b0, res, lat);
    checks++;
    if (res !== Z_OUT) begin errors++; $display("FAIL zero_result: got %h want %h", res, Z_OUT); end
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL zero_latency: got %0d want 18", lat); end
  endtask

  task automatic test_fips_round1();
    logic [127:0] res;
    int lat;
    run_round(R1_IN, R1_KEY, 1'b0, res, lat);
    checks++;
    if (res !== R1_OUT) begin errors++; $display("FAIL fips_round1: got %h want %h", res, R1_OUT); end
    run_round(R1_OUT, R2_KEY, 1'b0, res, lat);
    checks++;
    if (res !== R2_OUT) begin errors++; $display("FAIL fips_round2: got %h want %h", res, R2_OUT); end
  endtask

  task automatic test_final_round();
    logic [127:0] res;
    int lat;
`ifdef AES_FINAL_ROUND_EN
    run_round(128'heb598b1b402ea1c3f23813421e84e7d2, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
              1'b1, res, lat);
    checks++;
    if (res !== 128'h3925841d02dc09fbdc118597196a0b32) begin
      errors++; $display("FAIL final_round: got %h want 3925841d02dc09fbdc118597196a0b32", res);
    end
`else
    run_round(R1_IN, R1_KEY, 1'b1, res, lat);
    checks++;
    if (res !== R1_OUT) begin errors++; $display("FAIL final_flag_ignored: got %h want %h", res, R1_OUT); end
`endif
  endtask

  task automatic test_backpressure();
    int n;
    n = 0;
    state_in = R1_IN; rkey = R1_KEY; final_round = 1'b0; in_valid = 1'b1;
    step();
    state_in = 128'h0; rkey = 128'hffff;
    while (!out_valid && n < 60) begin step(); n++; end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_out_valid[%0d]: got %0b want 1", i, out_valid); end
      checks++;
      if (state_out !== R1_OUT) begin errors++; $display("FAIL bp_state_out[%0d]: got %h want %h", i, state_out, R1_OUT); end
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %0b want 0", i, in_ready); end
      step();
    end
    out_ready = 1'b1;
    in_valid  = 1'b0;
    step();
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_out_valid: got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid();
    logic [127:0] res;
    int lat;
    state_in = R1_IN; rkey = R1_KEY; final_round = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 7; i++) step();
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_out_valid: got %0b want 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %0b want 1", in_ready); end
    checks++;
    if (state_out !== 128'h0) begin errors++; $display("FAIL mid_reset_state_out: got %h want 0", state_out); end
    step();
    reset_n = 1'b1;
    step();
    run_round(R1_IN, R1_KEY, 1'b0, res, lat);
    checks++;
    if (res !== R1_OUT) begin errors++; $display("FAIL mid_reset_rerun: got %h want %h", res, R1_OUT); end
    checks++;
    if (lat !== 18) begin errors++; $display("FAIL mid_reset_latency: got %0d want 18", lat); end
  endtask

  task automatic test_back_to_back();
    logic [127:0] vin [4];
    logic [127:0] vkey [4];
    logic [127:0] exp_q [$];
    logic [127:0] e;
    int cyc, idx, got, last;
    logic acc;
    vin[0] = 128'h0;  vkey[0] = 128'h0;   exp_q.push_back(Z_OUT);
    vin[1] = R1_IN;   vkey[1] = R1_KEY;   exp_q.push_back(R1_OUT);
    vin[2] = R1_OUT;  vkey[2] = R2_KEY;   exp_q.push_back(R2_OUT);
    vin[3] = R2_OUT;  vkey[3] = R3_KEY;   exp_q.push_back(R3_OUT);
    cyc = 0; idx = 0; got = 0; last = 0;
    final_round = 1'b0; out_ready = 1'b1;
    state_in = vin[0]; rkey = vkey[0]; in_valid = 1'b1;
    while (got < 4 && cyc < 200) begin
      acc = in_ready & in_valid;
      if (out_valid) begin
        e = exp_q.pop_front();
        checks++;
        if (state_out !== e) begin errors++; $display("FAIL b2b_result[%0d]: got %h want %h", got, state_out, e); end
        if (got > 0) begin
          checks++;
          if (cyc - last != 19) begin errors++; $display("FAIL b2b_spacing[%0d]: got %0d want 19", got, cyc - last); end
        end
        last = cyc;
        got++;
      end
      step();
      cyc++;
      if (acc) begin
        idx++;
        if (idx < 4) begin state_in = vin[idx]; rkey = vkey[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (got != 4) begin errors++; $display("FAIL b2b_count: got %0d want 4", got); end
  endtask

  initial begin
    test_reset();
    test_zero();
    test_fips_round1();
    test_final_round();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
